// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep engine for small combinational blocks.
// Drives every input vector, samples the DUT and compares to EXP_TT.
module tt_sweep_checker #(
   parameter int                 N_IN   = 4,
   parameter int                 DWELL  = 1,
   parameter logic [2**N_IN-1:0] EXP_TT = 16'h8000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              gray,
   output logic [N_IN-1:0]   vec_out,
   input  logic              dut_f,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic              first_err_valid,
   output logic [N_IN-1:0]   first_err_idx,
   output logic [2**N_IN-1:0] cap_tt
);

   localparam int NV = 2**N_IN;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [N_IN:0]   idx;
   logic [N_IN:0]   idx_inc;
   logic [CW-1:0]   cnt;
   logic            gray_q;
   logic            go;
   logic            hit;
   logic            last;
   logic            miss;
   logic [N_IN:0]   err_inc;

   function automatic logic [N_IN-1:0] order(
      input logic [N_IN-1:0] i,
      input logic            g
   );
      order = g ? (i ^ (i >> 1)) : i;
   endfunction

   // abort outranks start, and start is only honoured outside RUN
   assign go      = start && !abort && (state != RUN);
   assign hit     = (state == RUN) && (cnt == CW'(DWELL - 1));
   assign last    = (idx == (N_IN+1)'(NV - 1));
   assign miss    = (dut_f != EXP_TT[vec_out]);
   assign err_inc = err_cnt + {{N_IN{1'b0}}, miss};
   assign idx_inc = idx + (N_IN+1)'(1);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next-state decode
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (go) nxt = RUN;
         RUN: begin
            if (abort)            nxt = IDLE;
            else if (hit && last) nxt = DONE;
         end
         DONE: if (go) nxt = RUN;
         default: nxt = IDLE;
      endcase
   end

   // sweep datapath: vector sequencing, sampling and scoring
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_out         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_cnt         <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         cap_tt          <= '0;
         idx             <= '0;
         cnt             <= '0;
         gray_q          <= 1'b0;
      end else if (state == RUN && abort) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         vec_out <= '0;
      end else if (go) begin
         busy            <= 1'b1;
         done            <= 1'b0;
         pass            <= 1'b0;
         idx             <= '0;
         cnt             <= '0;
         vec_out         <= order('0, gray);
         err_cnt         <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         cap_tt          <= '0;
         gray_q          <= gray;
      end else if (abort) begin
         done <= 1'b0;
      end else if (state == RUN) begin
         if (!hit) begin
            cnt <= cnt + CW'(1);
         end else begin
            cap_tt[vec_out] <= dut_f;
            err_cnt         <= err_inc;
            if (miss && !first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_idx   <= vec_out;
            end
            cnt <= '0;
            idx <= idx_inc;
            if (last) begin
               busy <= 1'b0;
               done <= 1'b1;
               pass <= (err_inc == '0);
            end else begin
               vec_out <= order(idx_inc[N_IN-1:0], gray_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: three configurations,
// lab DUT functions modelled combinationally from vec_out.
module tb_tt_sweep_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] start_s = '0;
   logic [2:0] abort_s = '0;
   logic [2:0] gray_s = '0;
   int         fsel = 0;

   logic [3:0]  vec0, vec1;
   logic [1:0]  vec2;
   logic        f0, f1, f2;
   logic [2:0]  busy_w, done_w, pass_w, fev_w;
   logic [4:0]  err0, err1;
   logic [2:0]  err2;
   logic [3:0]  fei0, fei1;
   logic [1:0]  fei2;
   logic [15:0] cap0, cap1;
   logic [3:0]  cap2;

   logic [31:0] o_vec[3], o_err[3], o_fei[3], o_cap[3];

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   assign f0 = (fsel == 1) ? |vec0 : &vec0;
   assign f1 = (fsel == 1) ? |vec1 : &vec1;
   assign f2 = (fsel == 3) ? ~^vec2 : ^vec2;

   assign o_vec[0] = 32'(vec0);
   assign o_vec[1] = 32'(vec1);
   assign o_vec[2] = 32'(vec2);
   assign o_err[0] = 32'(err0);
   assign o_err[1] = 32'(err1);
   assign o_err[2] = 32'(err2);
   assign o_fei[0] = 32'(fei0);
   assign o_fei[1] = 32'(fei1);
   assign o_fei[2] = 32'(fei2);
   assign o_cap[0] = 32'(cap0);
   assign o_cap[1] = 32'(cap1);
   assign o_cap[2] = 32'(cap2);

   tt_sweep_checker #(.N_IN(4), .DWELL(1), .EXP_TT(16'h8000)) u0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
      .gray(gray_s[0]), .vec_out(vec0), .dut_f(f0), .busy(busy_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err0),
      .first_err_valid(fev_w[0]), .first_err_idx(fei0), .cap_tt(cap0)
   );

   tt_sweep_checker #(.N_IN(4), .DWELL(3), .EXP_TT(16'h8000)) u1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
      .gray(gray_s[1]), .vec_out(vec1), .dut_f(f1), .busy(busy_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err1),
      .first_err_valid(fev_w[1]), .first_err_idx(fei1), .cap_tt(cap1)
   );

   tt_sweep_checker #(.N_IN(2), .DWELL(1), .EXP_TT(4'b0110)) u2 (
      .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]),
      .gray(gray_s[2]), .vec_out(vec2), .dut_f(f2), .busy(busy_w[2]),
      .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err2),
      .first_err_valid(fev_w[2]), .first_err_idx(fei2), .cap_tt(cap2)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int lab_f(int fs, int v, int n);
      case (fs)
         0:       return (v == (1 << n) - 1) ? 1 : 0;
         1:       return (v != 0) ? 1 : 0;
         2:       return $countones(v) % 2;
         default: return 1 - ($countones(v) % 2);
      endcase
   endfunction

   task automatic chk_reset(int k);
      check("rst_vec", o_vec[k], 0);
      check("rst_busy", 32'(busy_w[k]), 0);
      check("rst_done", 32'(done_w[k]), 0);
      check("rst_pass", 32'(pass_w[k]), 0);
      check("rst_err", o_err[k], 0);
      check("rst_fev", 32'(fev_w[k]), 0);
      check("rst_fei", o_fei[k], 0);
      check("rst_cap", o_cap[k], 0);
   endtask

   task automatic sweep(int k, bit g, int fs,
                        int ign_at, int abort_at, int rst_at);
      int          n, dw, cyc, v, f;
      int          exp_err, exp_fei, pre_err, pre_fei;
      bit          fev, pre_fev;
      logic [31:0] ett, exp_cap, ev;
      logic [31:0] q[$];
      n  = (k == 2) ? 2 : 4;
      dw = (k == 1) ? 3 : 1;
      ett = (k == 2) ? 32'h6 : 32'h8000;
      exp_err = 0; exp_fei = 0; fev = 0; exp_cap = '0;
      pre_err = 0; pre_fei = 0; pre_fev = 0;
      for (int i = 0; i < (1 << n); i++) begin
         v = g ? (i ^ (i >> 1)) : i;
         if (v == abort_at) begin
            pre_err = exp_err; pre_fei = exp_fei; pre_fev = fev;
         end
         f = lab_f(fs, v, n);
         if (f != 0) exp_cap[v] = 1'b1;
         if (f != int'(ett[v])) begin
            exp_err++;
            if (!fev) begin fev = 1; exp_fei = v; end
         end
         for (int d = 0; d < dw; d++) q.push_back(32'(v));
      end
      fsel = fs;
      gray_s[k] = g;
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
      cyc = 0;
      while (busy_w[k] && cyc < (1 << n) * dw + 8) begin
         ev = (q.size() != 0) ? q.pop_front() : 32'hDEAD;
         check("vec_seq", o_vec[k], ev);
         start_s[k] = (o_vec[k] == 32'(ign_at));
         if (o_vec[k] == 32'(abort_at)) begin
            abort_s[k] = 1'b1;
            @(negedge clk);
            abort_s[k] = 1'b0;
            check("abort_busy", 32'(busy_w[k]), 0);
            check("abort_done", 32'(done_w[k]), 0);
            check("abort_vec", o_vec[k], 0);
            check("abort_err", o_err[k], 32'(pre_err));
            check("abort_fev", 32'(fev_w[k]), 32'(pre_fev));
            check("abort_fei", o_fei[k], 32'(pre_fei));
            return;
         end
         if (o_vec[k] == 32'(rst_at)) begin
            rst = 1'b1;
            @(negedge clk);
            chk_reset(k);
            rst = 1'b0;
            return;
         end
         cyc++;
         @(negedge clk);
      end
      start_s[k] = 1'b0;
      check("busy_len", 32'(cyc), 32'((1 << n) * dw));
      check("sb_left", 32'(q.size()), 0);
      check("done", 32'(done_w[k]), 1);
      check("pass", 32'(pass_w[k]), (exp_err == 0) ? 1 : 0);
      check("err_cnt", o_err[k], 32'(exp_err));
      check("fe_valid", 32'(fev_w[k]), 32'(fev));
      check("fe_idx", o_fei[k], 32'(exp_fei));
      check("cap_tt", o_cap[k], exp_cap);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset(0);
      chk_reset(2);
      rst = 1'b0;
      @(negedge clk);

      sweep(0, 0, 0, -1, -1, -1);
      sweep(0, 0, 1, -1, -1, -1);
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      check("done_abort", 32'(done_w[0]), 0);
      check("cap_kept", o_cap[0], 32'hFFFE);

      sweep(1, 1, 0, -1, -1, -1);
      sweep(1, 1, 1, -1, -1, -1);

      sweep(0, 0, 1, 5, 7, -1);
      @(negedge clk);
      sweep(0, 0, 0, -1, -1, -1);

      sweep(0, 0, 1, -1, -1, 9);
      @(negedge clk);
      sweep(0, 0, 0, -1, -1, -1);

      sweep(2, 0, 2, -1, -1, -1);
      sweep(2, 0, 3, -1, -1, -1);
      sweep(2, 1, 3, -1, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
